// File: rtl/prog_delay_line.sv
// Multi-channel delay line with a run-time programmable tap (1..DEPTH enabled cycles).
// Each stage carries a valid bit; primed reports that the tap holds words written since the last reconfiguration.
module prog_delay_line #(
   parameter  int DEPTH         = 8,
   parameter  int BITS          = 64,
   parameter  int CH            = 2,
   parameter  int DEFAULT_DELAY = 8,
   localparam int DW            = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              flush,
   input  logic              cfg_we,
   input  logic [DW-1:0]     cfg_delay,
   input  logic [CH*BITS-1:0] d,
   input  logic [CH-1:0]     d_valid,
   output logic [CH*BITS-1:0] q,
   output logic [CH-1:0]     q_valid,
   output logic              primed,
   output logic [DW-1:0]     cur_delay
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [BITS-1:0]  stage_data [CH][DEPTH];
   logic [DEPTH-1:0] stage_vld  [CH];
   logic [DW-1:0]    delay_r;
   logic [DW-1:0]    fill;
   logic [DW-1:0]    fill_next;
   logic [AW-1:0]    tap;

   function automatic logic [DW-1:0] clamp_delay(input logic [DW-1:0] v);
      if (v == '0)
         return DW'(1);
      else if (v > DW'(DEPTH))
         return DW'(DEPTH);
      else
         return v;
   endfunction

   assign fill_next = (fill < DW'(DEPTH)) ? fill + DW'(1) : fill;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         delay_r <= DW'(DEFAULT_DELAY);
         fill    <= '0;
         for (int c = 0; c < CH; c++) begin
            stage_vld[c] <= '0;
            for (int s = 0; s < DEPTH; s++)
               stage_data[c][s] <= '0;
         end
      end else begin
         if (cfg_we)
            delay_r <= clamp_delay(cfg_delay);
         if (flush) begin
            fill <= '0;
            for (int c = 0; c < CH; c++) begin
               stage_vld[c] <= '0;
               for (int s = 0; s < DEPTH; s++)
                  stage_data[c][s] <= '0;
            end
         end else if (en) begin
            // a reconfiguring shift counts as the first fill of the new setting
            fill <= cfg_we ? DW'(1) : fill_next;
            for (int c = 0; c < CH; c++) begin
               stage_vld[c]     <= {stage_vld[c][DEPTH-2:0], d_valid[c]};
               stage_data[c][0] <= d[c*BITS +: BITS];
               for (int s = 1; s < DEPTH; s++)
                  stage_data[c][s] <= stage_data[c][s-1];
            end
         end else if (cfg_we) begin
            fill <= '0;
         end
      end
   end

   assign primed    = (fill >= delay_r);
   assign cur_delay = delay_r;
   assign tap       = AW'(delay_r - DW'(1));

   always_comb begin
      q       = '0;
      q_valid = '0;
      for (int c = 0; c < CH; c++) begin
         q[c*BITS +: BITS] = stage_data[c][tap];
         q_valid[c]        = stage_vld[c][tap] & primed;
      end
   end

endmodule

// File: tb/tb_prog_delay_line.sv
// Randomized directed bench for prog_delay_line against a history-queue reference model.
module tb_prog_delay_line;

   localparam int DEPTH = 8;
   localparam int BITS  = 64;
   localparam int CH    = 2;
   localparam int DDEF  = 8;
   localparam int DW    = $clog2(DEPTH + 1);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              en = 1'b0;
   logic              flush = 1'b0;
   logic              cfg_we = 1'b0;
   logic [DW-1:0]     cfg_delay = '0;
   logic [CH*BITS-1:0] d = '0;
   logic [CH-1:0]     d_valid = '0;
   logic [CH*BITS-1:0] q;
   logic [CH-1:0]     q_valid;
   logic              primed;
   logic [DW-1:0]     cur_delay;

   int total = 0;
   int bad   = 0;

   // Reference: newest accepted word at index 0, oldest at DEPTH-1.
   logic [CH*BITS-1:0] m_hd [$];
   logic [CH-1:0]      m_hv [$];
   int                 m_delay;
   int                 m_fill;

   prog_delay_line #(.DEPTH(DEPTH), .BITS(BITS), .CH(CH), .DEFAULT_DELAY(DDEF)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .flush(flush), .cfg_we(cfg_we),
      .cfg_delay(cfg_delay), .d(d), .d_valid(d_valid), .q(q), .q_valid(q_valid),
      .primed(primed), .cur_delay(cur_delay)
   );

   always #5 clk = ~clk;

   task automatic model_clear();
      m_hd.delete();
      m_hv.delete();
      for (int i = 0; i < DEPTH; i++) begin
         m_hd.push_back('0);
         m_hv.push_back('0);
      end
      m_fill = 0;
   endtask

   task automatic model_edge();
      if (!rst_n) begin
         model_clear();
         m_delay = DDEF;
      end else begin
         if (cfg_we) begin
            m_delay = (cfg_delay == 0) ? 1 : ((int'(cfg_delay) > DEPTH) ? DEPTH : int'(cfg_delay));
            m_fill  = 0;
         end
         if (flush) begin
            model_clear();
         end else if (en) begin
            m_hd.push_front(d);
            m_hv.push_front(d_valid);
            void'(m_hd.pop_back());
            void'(m_hv.pop_back());
            m_fill = (m_fill + 1 > DEPTH) ? DEPTH : m_fill + 1;
         end
      end
   endtask

   task automatic check(input string tag);
      logic [CH*BITS-1:0] exp_q;
      logic [CH-1:0]      exp_v;
      logic               exp_p;
      exp_p = (m_fill >= m_delay);
      exp_q = m_hd[m_delay-1];
      exp_v = exp_p ? m_hv[m_delay-1] : '0;
      total++;
      assert (q === exp_q) else begin
         bad++; $error("FAIL %s q: got %h expected %h", tag, q, exp_q);
      end
      total++;
      assert (q_valid === exp_v) else begin
         bad++; $error("FAIL %s q_valid: got %b expected %b", tag, q_valid, exp_v);
      end
      total++;
      assert (primed === exp_p) else begin
         bad++; $error("FAIL %s primed: got %b expected %b", tag, primed, exp_p);
      end
      total++;
      assert (cur_delay === DW'(m_delay)) else begin
         bad++; $error("FAIL %s cur_delay: got %0d expected %0d", tag, cur_delay, m_delay);
      end
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      #1;
      check(tag);
   endtask

   function automatic logic [BITS-1:0] r64();
      return {$urandom, $urandom};
   endfunction

   initial begin
      m_delay = DDEF;
      model_clear();

      // reset
      rst_n = 1'b0;
      step("reset");
      step("reset");
      rst_n = 1'b1;

      // sweep at default delay: ch0 carries the edge index
      en = 1'b1; d_valid = 2'b11;
      for (int i = 1; i <= 20; i++) begin
         d = {r64(), BITS'(i)};
         step("sweep");
      end
      total++;
      assert (q[BITS-1:0] === BITS'(13)) else begin
         bad++; $error("FAIL sweep_tail q_ch0: got %0d expected 13", q[BITS-1:0]);
      end

      // program delay 3 while streaming
      cfg_we = 1'b1; cfg_delay = DW'(3);
      d = {r64(), BITS'(21)};
      step("cfg3");
      cfg_we = 1'b0;
      for (int i = 22; i <= 28; i++) begin
         d = {r64(), BITS'(i)};
         step("delay3");
      end

      // clamp low
      cfg_we = 1'b1; cfg_delay = '0;
      d = {r64(), r64()};
      step("clamp0");
      cfg_we = 1'b0;
      for (int i = 0; i < 4; i++) begin
         d = {r64(), r64()};
         step("delay1");
      end

      // clamp high
      cfg_we = 1'b1; cfg_delay = DW'(15);
      d = {r64(), r64()};
      step("clamp15");
      cfg_we = 1'b0;
      for (int i = 0; i < 10; i++) begin
         d = {r64(), r64()};
         d_valid = 2'($urandom);
         step("delay8");
      end

      // stall with delay 4 primed
      cfg_we = 1'b1; cfg_delay = DW'(4); d_valid = 2'b11;
      d = {r64(), r64()};
      step("cfg4");
      cfg_we = 1'b0;
      for (int i = 0; i < 5; i++) begin
         d = {r64(), r64()};
         step("fill4");
      end
      en = 1'b0;
      for (int i = 0; i < 5; i++) begin
         d = {r64(), r64()};
         d_valid = 2'($urandom);
         step("stall");
      end
      en = 1'b1; d_valid = 2'b11;
      for (int i = 0; i < 5; i++) begin
         d = {r64(), r64()};
         step("resume");
      end

      // flush with en, 0xAA must never surface
      flush = 1'b1;
      d = {BITS'(8'hAA), BITS'(8'hAA)};
      step("flush");
      flush = 1'b0;
      for (int i = 0; i < 6; i++) begin
         d = {r64(), r64()};
         step("post_flush");
         total++;
         assert (q[BITS-1:0] !== BITS'(8'hAA)) else begin
            bad++; $error("FAIL flush_leak q_ch0: got %h expected not aa", q[BITS-1:0]);
         end
      end

      // flush and cfg on the same edge
      flush = 1'b1; cfg_we = 1'b1; cfg_delay = DW'(2);
      step("flush_cfg");
      flush = 1'b0; cfg_we = 1'b0;

      // alternating valid bubbles at delay 2
      for (int i = 0; i < 10; i++) begin
         d = {r64(), r64()};
         d_valid = (i % 2 == 0) ? 2'b01 : 2'b10;
         step("bubbles");
      end

      // random mix of enable, flush and reconfiguration
      for (int i = 0; i < 60; i++) begin
         en        = ($urandom_range(0, 3) != 0);
         flush     = ($urandom_range(0, 19) == 0);
         cfg_we    = ($urandom_range(0, 9) == 0);
         cfg_delay = DW'($urandom_range(0, 15));
         d         = {r64(), r64()};
         d_valid   = 2'($urandom);
         step("random");
      end
      flush = 1'b0; cfg_we = 1'b0; en = 1'b1;

      // mid-stream reset
      rst_n = 1'b0;
      d = {r64(), r64()};
      step("mid_reset");
      rst_n = 1'b1;
      en = 1'b0;
      step("after_reset");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/prog_delay_line.md
Name: prog_delay_line

Overview:
- Multi-channel, parametrised delay buffer.
- Each channel delays its data word by a run-time-programmable number of enabled clock cycles, from 1 to DEPTH.
- Every entry carries a valid bit, and the block reports when the pipeline has been primed for the current delay setting.
- Sits between CCIP MMIO-configured datapath stages to align streams of differing latency.

Parameters:
- DEPTH, 8, maximum delay in enabled cycles (number of stages); must be >= 2.
- BITS, 64, data width per channel.
- CH, 2, number of channels; all channels share enable, delay and flush.
- DEFAULT_DELAY, 8, delay loaded at reset; must be in 1..DEPTH.
- DW, $clog2(DEPTH+1), width of the delay configuration field (derived, not overridden).

Ports:
- clk  input  1  clock.
- rst_n  input  1  synchronous active-low reset.
- en  input  1  advance all stages by one slot on this rising edge.
- flush  input  1  clear all stages and the fill counter on this rising edge.
- cfg_we  input  1  load cfg_delay into the delay register.
- cfg_delay  input  DW  requested delay.
- d  input  CH*BITS  channel data, packed; channel c occupies bits [c*BITS +: BITS].
- d_valid  input  CH  per-channel valid for d.
- q  output  CH*BITS  delayed data, packed the same way as d.
- q_valid  output  CH  per-channel delayed valid, gated by primed.
- primed  output  1  fill count >= current delay.
- cur_delay  output  DW  delay currently in effect.

Behaviour:
- Reset: rst_n is synchronous, active-low; clock is clk.
  - While rst_n=0 at a rising edge: all stage data = 0, stage valids = 0, fill = 0, delay register = DEFAULT_DELAY.
  - Outputs after reset: q = 0, q_valid = 0, primed = 0, cur_delay = DEFAULT_DELAY.
  - rst_n has priority over every other input.
- Storage: per channel c, stages s[c][0..DEPTH-1], each holding BITS data plus 1 valid bit.
- Shift, on a rising edge with en=1 and flush=0:
  - s[c][0] <= {d_valid[c], d[c]}.
  - s[c][i] <= s[c][i-1] for i = 1..DEPTH-1.
  - Contents of the last stage are discarded.
- Hold: with en=0, all stages hold their contents.
- Output tap:
  - q[c] = data of s[c][cur_delay-1], combinational from registers; no extra output register.
  - q_valid[c] = valid of s[c][cur_delay-1] AND primed.
  - Latency: a word accepted at en-edge k appears on q after en-edge k+cur_delay-1, i.e. it is visible for exactly cur_delay enabled edges counted from its own.
- Delay configuration:
  - On cfg_we=1, the delay register is loaded with clamp(cfg_delay): 0 -> 1, values > DEPTH -> DEPTH.
  - cur_delay reflects the new value from the next cycle.
  - cfg_we also resets fill to 0. If en=1 on the same edge, the shift still happens and fill = 1.
  - Stage contents are never cleared by cfg_we.
- Fill counter:
  - Increments on each shift, saturating at DEPTH.
  - primed = (fill >= cur_delay).
- Flush:
  - On flush=1, all stage valids and data = 0 and fill = 0.
  - flush overrides en on the same edge: no shift, d is dropped.
  - cfg_we on the same edge as flush is still applied.
- No back-pressure: the block never stalls the producer. Stall by deasserting en.
- Boundary cases:
  - cur_delay = DEPTH taps the last stage.
  - cur_delay = 1 gives one-cycle visibility after the accepting edge.
  - fill saturation: fill never wraps.
  - Changing the delay while primed drops primed for cur_delay shifts, even if the new delay is smaller.

Test Plan:
- Reset, then sweep:
  - After reset: q = 0, q_valid = 0, primed = 0, cur_delay = 8.
  - Hold en=1, drive d_ch0 = i for i = 1..20 with d_valid = 2'b11.
  - Required: primed rises after the 8th edge; q_ch0 = i-7 after edge i for i >= 8; q_valid = 2'b11.
- Program delay:
  - cfg_we=1 with cfg_delay=3 and en=1, then continue streaming.
  - Required: cur_delay = 3; primed low for 2 more edges; then q_ch0 = i-2.
- Clamp:
  - cfg_delay=0 -> cur_delay=1, with q showing the word from the latest en edge.
  - cfg_delay=15 with DEPTH=8 -> cur_delay=8.
- Stall:
  - With delay 4 primed, drop en for 5 cycles.
  - Required: q, q_valid and primed hold; resume with no lost or duplicated word.
- Flush:
  - Assert flush with en=1 while data = 0xAA.
  - Required: next cycle q = 0, q_valid = 0, primed = 0; 0xAA never appears on q.
- Valid bubbles and mid-run reset:
  - Alternate d_valid between 01 and 10 at delay 2; q_valid must reproduce the pattern 1 edge later.
  - Assert rst_n=0 mid-stream; on the next edge all outputs return to their reset values and cur_delay = DEFAULT_DELAY.
